// File: rtl/fb_rect_writer.sv
// Rectangle fill / clear / swap engine for the write side of a double-buffered RGB565 frame buffer.
// Clips each rectangle to the buffer and emits one registered pixel write per cycle.
module fb_rect_writer #(
  parameter int FB_WIDTH     = 320,
  parameter int FB_HEIGHT    = 180,
  parameter int FB_SIZE      = 16,
  parameter int SWAP_HOLDOFF = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   cmd_valid_in,
  output logic                   cmd_ready_out,
  input  logic [1:0]             cmd_op_in,
  input  logic [8:0]             cmd_x_in,
  input  logic [7:0]             cmd_y_in,
  input  logic [8:0]             cmd_w_in,
  input  logic [7:0]             cmd_h_in,
  input  logic [15:0]            cmd_color_in,
  output logic                   busy_out,
  output logic                   write_clk_out,
  output logic [15:0]            write_data_out,
  output logic [2*FB_SIZE-1:0]   write_addr_out,
  output logic                   write_enable_out,
  output logic                   swap_buffer_out,
  output logic [FB_SIZE-1:0]     pix_count_out
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_FILL, S_SWAP, S_HOLD} state_t;

  localparam logic [1:0] OP_FILL  = 2'd0;
  localparam logic [1:0] OP_CLEAR = 2'd1;
  localparam logic [1:0] OP_SWAP  = 2'd2;

  localparam logic [9:0]         W10      = 10'(FB_WIDTH);
  localparam logic [9:0]         H10      = 10'(FB_HEIGHT);
  localparam logic [FB_SIZE-1:0] ROW_STEP = FB_SIZE'(FB_WIDTH);
  localparam int                 HW       = (SWAP_HOLDOFF > 1) ? $clog2(SWAP_HOLDOFF) : 1;
  localparam logic [HW-1:0]      HOLD_END = HW'(SWAP_HOLDOFF - 1);

  state_t r_state;
  state_t w_stateNext;

  logic [8:0]         r_x;
  logic [7:0]         r_y;
  logic [8:0]         r_w;
  logic [7:0]         r_h;
  logic [15:0]        r_color;
  logic [9:0]         r_xe;
  logic [9:0]         r_ye;
  logic [9:0]         r_col;
  logic [9:0]         r_row;
  logic [FB_SIZE-1:0] r_idx;
  logic [FB_SIZE-1:0] r_rowBase;
  logic [HW-1:0]      r_holdCnt;

  logic               w_accept;
  logic [9:0]         w_xSum;
  logic [9:0]         w_ySum;
  logic [9:0]         w_xe;
  logic [9:0]         w_ye;
  logic               w_empty;
  logic [FB_SIZE-1:0] w_rowBase;
  logic               w_colLast;
  logic               w_lastPix;

  logic                 w_readyNext;
  logic                 w_busyNext;
  logic                 w_weNext;
  logic [15:0]          w_dataNext;
  logic [2*FB_SIZE-1:0] w_addrNext;
  logic                 w_swapNext;
  logic [FB_SIZE-1:0]   w_pixNext;

  assign write_clk_out = clk_in;
  assign w_accept      = cmd_valid_in & cmd_ready_out;

  // Clipping uses 10-bit sums so x+w and y+h never wrap before the min().
  assign w_xSum    = {1'b0, r_x} + {1'b0, r_w};
  assign w_ySum    = {2'b0, r_y} + {2'b0, r_h};
  assign w_xe      = (w_xSum > W10) ? W10 : w_xSum;
  assign w_ye      = (w_ySum > H10) ? H10 : w_ySum;
  assign w_empty   = (r_w == 9'd0) || (r_h == 8'd0) || ({1'b0, r_x} >= W10) || ({2'b0, r_y} >= H10);
  assign w_rowBase = FB_SIZE'(r_y) * ROW_STEP + FB_SIZE'(r_x);
  assign w_colLast = (r_col == r_xe - 10'd1);
  assign w_lastPix = w_colLast && (r_row == r_ye - 10'd1);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= S_IDLE;
    else           r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op_in)
            OP_FILL, OP_CLEAR: w_stateNext = S_SETUP;
            OP_SWAP:           w_stateNext = S_SWAP;
            default:           w_stateNext = S_IDLE;
          endcase
        end
      end
      S_SETUP: w_stateNext = w_empty ? S_IDLE : S_FILL;
      S_FILL:  if (w_lastPix) w_stateNext = S_IDLE;
      S_SWAP:  w_stateNext = S_HOLD;
      S_HOLD:  if (r_holdCnt == HOLD_END) w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Ready follows registered IDLE-ness, so it is low the cycle after any accept that leaves IDLE.
  always_comb begin
    w_readyNext = (r_state == S_IDLE) && (w_stateNext == S_IDLE);
    w_busyNext  = (w_stateNext != S_IDLE);
    w_weNext    = (r_state == S_FILL);
    w_dataNext  = (r_state == S_FILL) ? r_color : 16'd0;
    w_addrNext  = (r_state == S_FILL) ? {{(FB_SIZE-1){1'b0}}, r_idx, 1'b0} : '0;
    w_swapNext  = (r_state == S_SWAP);
    w_pixNext   = pix_count_out;
    if (r_state == S_SWAP)
      w_pixNext = '0;
    else if ((r_state == S_FILL) && (pix_count_out != '1))
      w_pixNext = pix_count_out + 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cmd_ready_out    <= 1'b0;
      busy_out         <= 1'b0;
      write_enable_out <= 1'b0;
      write_data_out   <= '0;
      write_addr_out   <= '0;
      swap_buffer_out  <= 1'b0;
      pix_count_out    <= '0;
    end else begin
      cmd_ready_out    <= w_readyNext;
      busy_out         <= w_busyNext;
      write_enable_out <= w_weNext;
      write_data_out   <= w_dataNext;
      write_addr_out   <= w_addrNext;
      swap_buffer_out  <= w_swapNext;
      pix_count_out    <= w_pixNext;
    end
  end

  // The fill walk only adds: +1 along a row, +FB_WIDTH from the row base at each row end.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_x       <= '0;
      r_y       <= '0;
      r_w       <= '0;
      r_h       <= '0;
      r_color   <= '0;
      r_xe      <= '0;
      r_ye      <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_idx     <= '0;
      r_rowBase <= '0;
      r_holdCnt <= '0;
    end else begin
      if (w_accept && (r_state == S_IDLE) && (cmd_op_in == OP_CLEAR)) begin
        r_x     <= '0;
        r_y     <= '0;
        r_w     <= 9'(FB_WIDTH);
        r_h     <= 8'(FB_HEIGHT);
        r_color <= cmd_color_in;
      end else if (w_accept && (r_state == S_IDLE) && (cmd_op_in == OP_FILL)) begin
        r_x     <= cmd_x_in;
        r_y     <= cmd_y_in;
        r_w     <= cmd_w_in;
        r_h     <= cmd_h_in;
        r_color <= cmd_color_in;
      end

      if (r_state == S_SETUP) begin
        r_xe      <= w_xe;
        r_ye      <= w_ye;
        r_col     <= {1'b0, r_x};
        r_row     <= {2'b0, r_y};
        r_rowBase <= w_rowBase;
        r_idx     <= w_rowBase;
      end else if (r_state == S_FILL) begin
        if (w_colLast) begin
          r_col     <= {1'b0, r_x};
          r_row     <= r_row + 10'd1;
          r_rowBase <= r_rowBase + ROW_STEP;
          r_idx     <= r_rowBase + ROW_STEP;
        end else begin
          r_col <= r_col + 10'd1;
          r_idx <= r_idx + 1'b1;
        end
      end

      if (r_state == S_HOLD) r_holdCnt <= r_holdCnt + 1'b1;
      else                   r_holdCnt <= '0;
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Scoreboard bench for fb_rect_writer: a rectangle model queues expected writes and swaps,
// and a negedge monitor pops and compares them whenever the engine writes or swaps.
module tb_fb_rect_writer;

  localparam int FBW = 320;
  localparam int FBH = 180;
  localparam logic [1:0] OP_FILL  = 2'd0;
  localparam logic [1:0] OP_CLEAR = 2'd1;
  localparam logic [1:0] OP_SWAP  = 2'd2;
  localparam logic [1:0] OP_NOP   = 2'd3;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        cmdValid = 1'b0;
  logic [1:0]  cmdOp = '0;
  logic [8:0]  cmdX = '0;
  logic [7:0]  cmdY = '0;
  logic [8:0]  cmdW = '0;
  logic [7:0]  cmdH = '0;
  logic [15:0] cmdColor = '0;

  logic        cmdReady;
  logic        busy;
  logic        writeClk;
  logic [15:0] writeData;
  logic [31:0] writeAddr;
  logic        writeEnable;
  logic        swapBuffer;
  logic [15:0] pixCount;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t expQ[$];
  int  expSwaps = 0;
  int  modelPix = 0;
  int  errors = 0;
  int  checks = 0;

  fb_rect_writer dut (
    .clk_in           (clk),
    .rst_n_in         (rstN),
    .cmd_valid_in     (cmdValid),
    .cmd_ready_out    (cmdReady),
    .cmd_op_in        (cmdOp),
    .cmd_x_in         (cmdX),
    .cmd_y_in         (cmdY),
    .cmd_w_in         (cmdW),
    .cmd_h_in         (cmdH),
    .cmd_color_in     (cmdColor),
    .busy_out         (busy),
    .write_clk_out    (writeClk),
    .write_data_out   (writeData),
    .write_addr_out   (writeAddr),
    .write_enable_out (writeEnable),
    .swap_buffer_out  (swapBuffer),
    .pix_count_out    (pixCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s", name);
  endtask

  // Reference: the clipped rectangle as a list of raster-order pixel writes.
  task automatic modelCommand(input logic [1:0] op, input int x, input int y, input int w,
                              input int h, input logic [15:0] color);
    int xe, ye;
    wr_t e;
    if (op == OP_CLEAR) begin
      x = 0; y = 0; w = FBW; h = FBH;
    end
    if (op == OP_FILL || op == OP_CLEAR) begin
      if (w != 0 && h != 0 && x < FBW && y < FBH) begin
        xe = (x + w < FBW) ? x + w : FBW;
        ye = (y + h < FBH) ? y + h : FBH;
        for (int yy = y; yy < ye; yy++) begin
          for (int xx = x; xx < xe; xx++) begin
            e.addr = 32'((yy * FBW + xx) * 2);
            e.data = color;
            expQ.push_back(e);
          end
        end
        modelPix = modelPix + (xe - x) * (ye - y);
        if (modelPix > 65535) modelPix = 65535;
      end
    end else if (op == OP_SWAP) begin
      expSwaps++;
      modelPix = 0;
    end
  endtask

  // Returns 1 ns after the accept edge with valid already dropped.
  task automatic applyStimulus(input logic [1:0] op, input int x, input int y, input int w,
                               input int h, input logic [15:0] color);
    int n = 0;
    @(negedge clk);
    cmdOp = op; cmdX = 9'(x); cmdY = 8'(y); cmdW = 9'(w); cmdH = 8'(h); cmdColor = color;
    cmdValid = 1'b1;
    while (!cmdReady && n < 70000) begin
      @(negedge clk);
      n++;
    end
    if (!cmdReady) failNow("ready_timeout");
    modelCommand(op, x, y, w, h, color);
    @(posedge clk);
    #1 cmdValid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    @(negedge clk);
    while (!(cmdReady && expQ.size() == 0) && n < 70000) begin
      @(negedge clk);
      n++;
    end
    if (!(cmdReady && expQ.size() == 0)) failNow("drain_timeout");
  endtask

  task automatic runTest1();
    applyStimulus(OP_FILL, 10, 5, 3, 2, 16'hF800);
    @(negedge clk);
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_we_cycle1", writeEnable, 0);
    @(negedge clk);
    checkOutput("t1_we_cycle2", writeEnable, 0);
    @(negedge clk);
    checkOutput("t1_first_we", writeEnable, 1);
    checkOutput("t1_first_addr", writeAddr, 3220);
    repeat (5) @(negedge clk);
    checkOutput("t1_last_addr", writeAddr, 3864);
    checkOutput("t1_ready_at_last", cmdReady, 0);
    @(negedge clk);
    checkOutput("t1_ready_after", cmdReady, 1);
    checkOutput("t1_we_after", writeEnable, 0);
  endtask

  always @(negedge clk) begin
    if (rstN) begin
      if (writeEnable) begin
        checkOutput("no_swap_with_write", swapBuffer, 0);
        if (expQ.size() == 0) begin
          failNow("unexpected_write");
        end else begin
          wr_t e;
          e = expQ.pop_front();
          checkOutput("write_addr", writeAddr, e.addr);
          checkOutput("write_data", writeData, 32'(e.data));
        end
      end else begin
        checkOutput("data_idle", writeData, 0);
      end
      if (swapBuffer) begin
        if (expSwaps == 0) failNow("unexpected_swap");
        else expSwaps--;
        checkOutput("swap_pix_clear", pixCount, 0);
      end
    end
  end

  initial begin
    int n;
    int r;
    logic [15:0] c;

    repeat (3) @(negedge clk);
    checkOutput("rst_ready", cmdReady, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_we", writeEnable, 0);
    checkOutput("rst_pix", pixCount, 0);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_release", cmdReady, 1);

    runTest1();
    checkOutput("t1_pix", pixCount, 32'(modelPix));

    applyStimulus(OP_FILL, 318, 179, 5, 5, 16'h07E0);
    waitDrain();
    checkOutput("t2_pix", pixCount, 32'(modelPix));

    applyStimulus(OP_FILL, 20, 20, 0, 10, 16'h1234);
    @(negedge clk); checkOutput("t3a_ready_c1", cmdReady, 0);
    @(negedge clk); checkOutput("t3a_ready_c2", cmdReady, 0);
    @(negedge clk); checkOutput("t3a_ready_c3", cmdReady, 1);
    applyStimulus(OP_FILL, 320, 20, 5, 5, 16'h1234);
    @(negedge clk); checkOutput("t3b_ready_c1", cmdReady, 0);
    @(negedge clk); checkOutput("t3b_ready_c2", cmdReady, 0);
    @(negedge clk); checkOutput("t3b_ready_c3", cmdReady, 1);

    applyStimulus(OP_SWAP, 0, 0, 0, 0, 16'h0);
    waitDrain();
    applyStimulus(OP_CLEAR, 0, 0, 0, 0, 16'h001F);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmdReady && n < 70000);
    checkOutput("t4_clear_cycles", n, 57600 + 3);
    checkOutput("t4_pix", pixCount, 57600);
    checkOutput("t4_queue_empty", expQ.size(), 0);

    applyStimulus(OP_SWAP, 0, 0, 0, 0, 16'h0);
    @(negedge clk);
    checkOutput("t5_swap_c1", swapBuffer, 0);
    checkOutput("t5_ready_c1", cmdReady, 0);
    @(negedge clk);
    checkOutput("t5_swap_c2", swapBuffer, 1);
    checkOutput("t5_pix", pixCount, 0);
    @(negedge clk);
    checkOutput("t5_swap_c3", swapBuffer, 0);
    checkOutput("t5_ready_c3", cmdReady, 0);
    @(negedge clk); checkOutput("t5_ready_c4", cmdReady, 0);
    @(negedge clk); checkOutput("t5_ready_c5", cmdReady, 1);

    applyStimulus(OP_CLEAR, 0, 0, 0, 0, 16'hABCD);
    repeat (3) @(posedge clk);
    #2 rstN = 1'b0;
    expQ.delete();
    modelPix = 0;
    #1;
    checkOutput("t6_we", writeEnable, 0);
    checkOutput("t6_data", writeData, 0);
    checkOutput("t6_addr", writeAddr, 0);
    checkOutput("t6_ready", cmdReady, 0);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_swap", swapBuffer, 0);
    checkOutput("t6_pix", pixCount, 0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("t6_ready_release", cmdReady, 1);
    runTest1();
    checkOutput("t6_repeat_pix", pixCount, 32'(modelPix));

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      c = 16'($urandom);
      if (r <= 6)
        applyStimulus(OP_FILL, $urandom_range(0, 330), $urandom_range(0, 190),
                      $urandom_range(0, 24), $urandom_range(0, 12), c);
      else if (r == 7)
        applyStimulus(OP_SWAP, 0, 0, 0, 0, c);
      else if (r == 8) begin
        applyStimulus(OP_NOP, $urandom_range(0, 511), 0, 0, 0, c);
        @(negedge clk);
        checkOutput("nop_ready", cmdReady, 1);
      end else
        applyStimulus(OP_FILL, $urandom_range(0, 511), $urandom_range(0, 255),
                      $urandom_range(0, 511), $urandom_range(0, 6), c);
      if ((i % 8) == 7) begin
        waitDrain();
        checkOutput("rand_pix", pixCount, 32'(modelPix));
      end
    end
    waitDrain();
    repeat (4) @(negedge clk);
    checkOutput("final_pix", pixCount, 32'(modelPix));
    checkOutput("final_swaps_pending", expSwaps, 0);
    checkOutput("final_queue", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog");
  end

endmodule
